// File: rtl/prach_fcw_sched.sv
// prach_fcw_sched: PRACH TDM channel/sync generator with a double-buffered FCW bank applied on frame boundaries.
module prach_fcw_sched #(
  parameter int NUM_ANT   = 3,
  parameter int NUM_CH    = 8,
  parameter int FCW_W     = 17,
  parameter int FRAME_LEN = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csr_wr_en,
  input  logic [4:0]                       csr_wr_addr,
  input  logic [FCW_W-1:0]                 csr_wr_data,
  input  logic                             csr_commit,
  input  logic                             csr_err_clr,
  output logic                             csr_pending,
  output logic                             csr_err,
  output logic                             commit_done,
  output logic [7:0]                       dout_chn,
  output logic                             sync_out,
  output logic [FCW_W*NUM_ANT*NUM_CH-1:0]  ctrl_fcw
);
  localparam int N  = NUM_ANT * NUM_CH;
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;
  state_t state, state_n;
  logic [CW-1:0] fc, fc_n;
  logic [FCW_W-1:0] shadow [N];
  logic wr_ok, wr_bad;
  assign fc_n   = (fc == LAST) ? '0 : fc + 1'b1;
  assign wr_ok  = csr_wr_en && (32'(csr_wr_addr) < N) && !csr_pending;
  assign wr_bad = csr_wr_en && !wr_ok;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = (state == IDLE)    ? (csr_commit ? PENDING : IDLE) :
              (state == PENDING) ? ((fc == LAST) ? APPLY : PENDING) : IDLE;
  // pending covers the apply cycle too, so writes stay blocked until the bank is live
  always_comb begin
    csr_pending = (state != IDLE);
    commit_done = (state == APPLY);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fc       <= LAST;
      sync_out <= 1'b0;
      dout_chn <= '0;
      csr_err  <= 1'b0;
      ctrl_fcw <= '0;
      for (int i = 0; i < N; i++) shadow[i] <= '0;
    end else begin
      fc       <= fc_n;
      sync_out <= (fc_n == '0);
      dout_chn <= 8'(32'(fc_n) % NUM_CH);
      csr_err  <= wr_bad | (csr_err & ~csr_err_clr);
      if (wr_ok) shadow[csr_wr_addr] <= csr_wr_data;
      if (state == PENDING && fc == LAST)
        for (int i = 0; i < N; i++) ctrl_fcw[i*FCW_W +: FCW_W] <= shadow[i];
    end
  end
endmodule

// File: tb/tb_prach_fcw_sched.sv
// tb_prach_fcw_sched: reference-model scoreboard plus directed frame/commit corner cases.
module tb_prach_fcw_sched;
  localparam int NA = 3, NC = 8, FW = 17, FL = 256, N = NA * NC, W = FW * N;
  logic clk = 0, rst = 1, wr_en = 0, commit = 0, err_clr = 0;
  logic [4:0] addr = 0;
  logic [FW-1:0] data = 0;
  logic pend, err, done, sync;
  logic [7:0] chn;
  logic [W-1:0] ctrl;
  always #5 clk = ~clk;
  prach_fcw_sched #(.NUM_ANT(NA), .NUM_CH(NC), .FCW_W(FW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .csr_wr_en(wr_en), .csr_wr_addr(addr), .csr_wr_data(data),
    .csr_commit(commit), .csr_err_clr(err_clr), .csr_pending(pend), .csr_err(err),
    .commit_done(done), .dout_chn(chn), .sync_out(sync), .ctrl_fcw(ctrl));
  typedef struct packed {logic s; logic [7:0] c; logic p, e, d; logic [W-1:0] f;} obs_t;
  typedef struct {logic we; logic [4:0] a; logic [FW-1:0] d; logic c, clr, xe, xp;} vec_t;
  obs_t sb[$];
  int checks = 0, errors = 0;
  int m_fc = FL - 1, m_st = 0;
  logic m_err = 0, m_sync = 0;
  logic [7:0] m_chn = 0;
  logic [FW-1:0] m_sh [N];
  logic [W-1:0] m_ctrl = '0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] wd(input logic [W-1:0] v, input int i);
    return W'(v[i*FW +: FW]);
  endfunction
  task automatic tick();
    logic p, es;
    int ofc;
    obs_t e, o;
    if (rst) begin
      m_fc = FL - 1; m_st = 0; m_err = 0; m_ctrl = '0; m_sync = 0; m_chn = 0;
      for (int i = 0; i < N; i++) m_sh[i] = '0;
    end else begin
      p  = (m_st != 0);
      es = wr_en && (addr >= N || p);
      if (wr_en && addr < N && !p) m_sh[addr] = data;
      m_err = es || (m_err && !err_clr);
      ofc = m_fc;
      m_fc = (m_fc + 1) % FL;
      if (m_st == 0) m_st = commit ? 1 : 0;
      else if (m_st == 1) begin
        if (ofc == FL - 1) begin
          m_st = 2;
          for (int i = 0; i < N; i++) m_ctrl[i*FW +: FW] = m_sh[i];
        end
      end else m_st = 0;
      m_sync = (m_fc == 0);
      m_chn = 8'(m_fc % NC);
    end
    sb.push_back('{m_sync, m_chn, m_st != 0, m_err, m_st == 2, m_ctrl});
    @(posedge clk); #1;
    o = '{sync, chn, pend, err, done, ctrl};
    e = sb.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL cycle: got s=%b c=%0d p=%b e=%b d=%b f=%h want s=%b c=%0d p=%b e=%b d=%b f=%h",
               o.s, o.c, o.p, o.e, o.d, o.f, e.s, e.c, e.p, e.e, e.d, e.f);
    end
  endtask
  task automatic run_to(input int t);
    int n = 0;
    while (m_fc != t && n < FL + 2) begin tick(); n++; end
    chk("run_to timeout", W'(n < FL + 2), W'(1));
  endtask
  task automatic write1(input logic [4:0] a, input logic [FW-1:0] d, input logic c);
    wr_en = 1; addr = a; data = d; commit = c;
    tick();
    wr_en = 0; commit = 0;
  endtask
  initial begin
    vec_t v[7];
    logic [W-1:0] saved;
    int last, n, k, nd;
    v[0] = '{1, 5'd24, 17'h00005, 0, 0, 1, 0};
    v[1] = '{0, 5'd0,  17'h0,     0, 0, 1, 0};
    v[2] = '{0, 5'd0,  17'h0,     1, 0, 1, 1};
    v[3] = '{1, 5'd3,  17'h00777, 0, 0, 1, 1};
    v[4] = '{0, 5'd0,  17'h0,     0, 1, 0, 1};
    v[5] = '{1, 5'd31, 17'h00001, 0, 1, 1, 1};
    v[6] = '{0, 5'd0,  17'h0,     0, 1, 0, 1};
    repeat (3) tick();
    chk("rst sync", W'(sync), 0);
    chk("rst chn", W'(chn), 0);
    chk("rst pend", W'(pend), 0);
    chk("rst err", W'(err), 0);
    chk("rst done", W'(done), 0);
    chk("rst ctrl", ctrl, 0);
    rst = 0;
    last = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      chk("chn seq", W'(chn), W'(i % NC));
      if (i == 0) chk("first sync", W'(sync), 1);
      if (sync) begin
        chk("chn at sync", W'(chn), 0);
        if (last >= 0) chk("sync period", W'(i - last), W'(FL));
        last = i;
      end
    end
    write1(5'd9, 17'h1ABCD, 0);
    run_to(100);
    commit = 1; tick(); commit = 0;
    n = 0;
    while (!sync && n < FL + 2) begin tick(); n++; end
    chk("commit sync", W'(sync), 1);
    chk("commit done", W'(done), 1);
    chk("commit word9", wd(ctrl, 9), W'(17'h1ABCD));
    chk("commit others", ctrl & ~(W'(17'h1FFFF) << (9 * FW)), 0);
    tick();
    run_to(255);
    write1(5'd0, 17'h1FFFF, 1);
    n = pend ? 1 : 0;
    k = 0;
    nd = 0;
    while (pend && k < 600) begin
      tick(); k++;
      if (pend) n++;
      if (done) begin
        nd++;
        chk("late commit sync", W'(sync), 1);
        chk("late word0", wd(ctrl, 0), W'(17'h1FFFF));
        chk("late word9", wd(ctrl, 9), W'(17'h1ABCD));
      end
    end
    chk("pending length", W'(n), W'(257));
    chk("late done count", W'(nd), 1);
    saved = ctrl;
    run_to(10);
    for (int i = 0; i < 7; i++) begin
      wr_en = v[i].we; addr = v[i].a; data = v[i].d; commit = v[i].c; err_clr = v[i].clr;
      tick();
      wr_en = 0; commit = 0; err_clr = 0;
      chk($sformatf("vec%0d err", i), W'(err), W'(v[i].xe));
      chk($sformatf("vec%0d pend", i), W'(pend), W'(v[i].xp));
    end
    n = 0;
    while (!done && n < FL + 2) begin tick(); n++; end
    chk("illegal done", W'(done), 1);
    chk("illegal shadow", ctrl, saved);
    tick();
    write1(5'd23, 17'h12345, 0);
    commit = 1; tick(); commit = 0;
    repeat (3) tick();
    commit = 1; tick(); commit = 0;
    nd = 0;
    for (int i = 0; i < 700; i++) begin
      commit = done;
      tick();
      commit = 0;
      if (done) nd++;
    end
    chk("b2b done count", W'(nd), 1);
    chk("b2b word23", wd(ctrl, 23), W'(17'h12345));
    chk("b2b idle", W'(pend), 0);
    run_to(40);
    write1(5'd5, 17'h0AAAA, 1);
    run_to(50);
    chk("mid pend", W'(pend), 1);
    rst = 1; tick(); rst = 0;
    tick();
    chk("post rst sync", W'(sync), 1);
    chk("post rst chn", W'(chn), 0);
    nd = 0;
    for (int i = 0; i < 600; i++) begin tick(); if (done) nd++; end
    chk("rst no done", W'(nd), 0);
    chk("rst ctrl zero", ctrl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prach_fcw_sched.md
PRACH_FCW_SCHED -- requirements
Module: prach_fcw_sched

Interface
REQ-001 SHALL have parameter NUM_ANT, default 3, antenna branches.
REQ-002 SHALL have parameter NUM_CH, default 8, TDM channels per branch.
REQ-003 SHALL have parameter FCW_W, default 17, frequency control word width.
REQ-004 SHALL have parameter FRAME_LEN, default 256, cycles between sync pulses; legal only if a multiple of NUM_CH and >= 2*NUM_CH.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port csr_wr_en  input  1  shadow-bank write strobe.
REQ-008 SHALL have port csr_wr_addr  input  5  word address = ant*NUM_CH + ch.
REQ-009 SHALL have port csr_wr_data  input  FCW_W  FCW value to write.
REQ-010 SHALL have port csr_commit  input  1  request to apply the shadow bank.
REQ-011 SHALL have port csr_err_clr  input  1  clears the sticky error.
REQ-012 SHALL have port csr_pending  output  1  commit accepted, not yet applied.
REQ-013 SHALL have port csr_err  output  1  sticky illegal-write flag.
REQ-014 SHALL have port commit_done  output  1  one-cycle pulse when the active bank is loaded.
REQ-015 SHALL have port dout_chn  output  8  TDM channel index for the mixer input.
REQ-016 SHALL have port sync_out  output  1  frame-start pulse for the mixer sync_in.
REQ-017 SHALL have port ctrl_fcw  output  FCW_W x NUM_ANT x NUM_CH  active FCW bank.

Function
REQ-018 SHALL keep a free-running frame counter fc, 0..FRAME_LEN-1, wrapping to 0.
REQ-019 SHALL register all outputs, with sync_out=1 exactly in cycles where fc==0 and dout_chn = fc mod NUM_CH.
REQ-020 SHALL write csr_wr_data into shadow[addr] on the next edge when csr_wr_en=1, addr < NUM_ANT*NUM_CH and csr_pending=0.
REQ-021 SHALL ignore a write with addr >= NUM_ANT*NUM_CH and set csr_err=1.
REQ-022 SHALL ignore any write while csr_pending=1 and set csr_err=1.
REQ-023 SHALL hold csr_err until csr_err_clr=1 clears it; a same-cycle set and clear SHALL leave it set.
REQ-024 SHALL implement a state machine IDLE -> PENDING on csr_commit=1, PENDING -> APPLY at the edge where fc==FRAME_LEN-1, and APPLY -> IDLE after one cycle.
REQ-025 SHALL drive csr_pending=1 in PENDING.
REQ-026 SHALL load ctrl_fcw from the shadow bank on entering APPLY, in the same cycle that commit_done=1 and sync_out=1, so a bank change always aligns to a frame start.
REQ-027 SHALL ignore csr_commit while in PENDING or APPLY, with no error raised.
REQ-028 SHALL accept a write and a commit in the same IDLE cycle, with that write included in the commit.
REQ-029 SHALL, when a commit arrives in the cycle fc==FRAME_LEN-1, apply it at the following frame boundary, not the current one.
REQ-030 SHALL leave ctrl_fcw unchanged except on APPLY; the shadow bank is never visible directly.
REQ-031 SHALL treat FCW values as unsigned and pass them unmodified, with no truncation or saturation.

Reset
REQ-032 SHALL, while rst=1, set ctrl_fcw, all shadow words, csr_err, csr_pending, commit_done and sync_out to 0, dout_chn to 0, and the state to IDLE.
REQ-033 SHALL hold fc at FRAME_LEN-1 during reset so that the first edge with rst=0 yields sync_out=1 and dout_chn=0.
REQ-034 SHALL, when reset is asserted mid-PENDING, discard the commit and leave ctrl_fcw at 0.

Verification
REQ-035 Bench SHALL check the reset release: after it, sync_out pulses every 256 cycles, and dout_chn runs 0..7 repeating and is 0 on every sync.
REQ-036 Bench SHALL check a commit: write addr 9 = 0x1ABCD and commit at fc=100 -> ctrl_fcw[1][1]=0x1ABCD in the next fc==0 cycle, with commit_done=1 and sync_out=1 in that same cycle; other words stay 0.
REQ-037 Bench SHALL check commit on the last frame cycle: commit at fc=255 -> applied at the fc==0 one full frame later, and csr_pending is high for 257 cycles.
REQ-038 Bench SHALL check an illegal write: write addr 24 -> csr_err=1 and the shadow is unchanged; then a write to addr 3 while pending -> ignored and csr_err stays 1; then csr_err_clr -> csr_err=0.
REQ-039 Bench SHALL check a back-to-back commit: a second csr_commit during PENDING -> exactly one commit_done pulse.
REQ-040 Bench SHALL check reset mid-pending: rst for 1 cycle at fc=50 while pending -> no commit_done, ctrl_fcw all 0, and sync_out=1 on the first cycle after rst falls.
